// File: rtl/jump_ctrl.sv
// Jump controller: resolves branch / call / return requests into an absolute PC jump.
// Optional PC-relative branch support is enabled by defining JUMP_CTRL_REL_EN.
module jump_ctrl #(
  parameter int D = 9,
  parameter int K = 3,
  parameter int S = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [D:0]                 prog_ctr,
  input  logic                       br_req,
  input  logic                       br_cond,
  input  logic                       call_req,
  input  logic                       ret_req,
  input  logic [K-1:0]               lut_idx,
  input  logic                       lut_we,
  input  logic [K-1:0]               lut_waddr,
  input  logic [D:0]                 lut_wdata,
`ifdef JUMP_CTRL_REL_EN
  input  logic                       rel_req,
  input  logic [7:0]                 rel_off,
`endif
  output logic                       absjump_en,
  output logic [D:0]                 target,
  output logic [$clog2(S+1)-1:0]     depth,
  output logic                       stk_ovf,
  output logic                       stk_unf
);

  localparam int AW = D + 1;
  localparam int DW = $clog2(S + 1);
  localparam int SW = $clog2(S);
  localparam int LN = 1 << K;

  logic [AW-1:0] lut_r [LN];
  logic [AW-1:0] stk_r [S];
  logic [DW-1:0] depth_r;
  logic          ovf_r;
  logic          unf_r;

  logic          jump_s;
  logic [AW-1:0] tgt_s;
  logic          push_s;
  logic          pop_s;
  logic          set_ovf_s;
  logic          set_unf_s;
  logic [AW-1:0] ret_addr_s;
  logic [DW-1:0] depth_m1_s;
  logic [SW-1:0] top_idx_s;
  logic [SW-1:0] push_idx_s;
  logic          full_s;
  logic          empty_s;

  // Stack pointer arithmetic and return-address generation
  always_comb begin
    ret_addr_s = prog_ctr + {{(AW-1){1'b0}}, 1'b1};
    depth_m1_s = depth_r - {{(DW-1){1'b0}}, 1'b1};
    top_idx_s  = depth_m1_s[SW-1:0];
    push_idx_s = depth_r[SW-1:0];
    full_s     = (depth_r == DW'(S));
    empty_s    = (depth_r == {DW{1'b0}});
  end

  // Request arbitration and jump decision (ret > call > [rel >] br)
  always_comb begin
    jump_s    = 1'b0;
    tgt_s     = {AW{1'b0}};
    push_s    = 1'b0;
    pop_s     = 1'b0;
    set_ovf_s = 1'b0;
    set_unf_s = 1'b0;
    if (ret_req) begin
      if (!empty_s) begin
        jump_s = 1'b1;
        tgt_s  = stk_r[top_idx_s];
        pop_s  = 1'b1;
      end else begin
        set_unf_s = 1'b1;
      end
    end else if (call_req) begin
      if (!full_s) begin
        jump_s = 1'b1;
        tgt_s  = lut_r[lut_idx];
        push_s = 1'b1;
      end else begin
        set_ovf_s = 1'b1;
      end
`ifdef JUMP_CTRL_REL_EN
    end else if (rel_req) begin
      // Offset is sign-extended to the address width; requires D >= 7.
      if (br_cond) begin
        jump_s = 1'b1;
        tgt_s  = prog_ctr + {{(AW-8){rel_off[7]}}, rel_off};
      end else begin
        jump_s = 1'b0;
      end
`endif
    end else if (br_req) begin
      if (br_cond) begin
        jump_s = 1'b1;
        tgt_s  = lut_r[lut_idx];
      end else begin
        jump_s = 1'b0;
      end
    end else begin
      jump_s = 1'b0;
    end
  end

  // Jump outputs are forced quiet while reset is held
  always_comb begin
    if (reset && jump_s) begin
      absjump_en = 1'b1;
      target     = tgt_s;
    end else begin
      absjump_en = 1'b0;
      target     = {AW{1'b0}};
    end
  end

  // Jump-target lookup table
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LN; i++) begin
        lut_r[i] <= {AW{1'b0}};
      end
    end else if (lut_we) begin
      lut_r[lut_waddr] <= lut_wdata;
    end
  end

  // Return-address register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < S; i++) begin
        stk_r[i] <= {AW{1'b0}};
      end
    end else if (push_s) begin
      stk_r[push_idx_s] <= ret_addr_s;
    end
  end

  // Stack occupancy pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_r <= {DW{1'b0}};
    end else if (push_s) begin
      depth_r <= depth_r + {{(DW-1){1'b0}}, 1'b1};
    end else if (pop_s) begin
      depth_r <= depth_m1_s;
    end
  end

  // Sticky overflow / underflow flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (set_ovf_s) ovf_r <= 1'b1;
      if (set_unf_s) unf_r <= 1'b1;
    end
  end

  assign depth   = depth_r;
  assign stk_ovf = ovf_r;
  assign stk_unf = unf_r;

endmodule

// File: tb/tb_jump_ctrl.sv
// Scoreboard bench for jump_ctrl: directed test-plan sequences followed by random traffic,
// checked against a queue-based behavioural model.
module tb_jump_ctrl;

  logic       clk;
  logic       reset;
  logic [9:0] prog_ctr;
  logic       br_req, br_cond, call_req, ret_req;
  logic [2:0] lut_idx;
  logic       lut_we;
  logic [2:0] lut_waddr;
  logic [9:0] lut_wdata;
  logic       rel_req;
  logic [7:0] rel_off;
  logic       absjump_en;
  logic [9:0] target;
  logic [2:0] depth;
  logic       stk_ovf, stk_unf;

  jump_ctrl #(.D(9), .K(3), .S(4)) dut (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr),
    .br_req(br_req), .br_cond(br_cond), .call_req(call_req), .ret_req(ret_req),
    .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
`ifdef JUMP_CTRL_REL_EN
    .rel_req(rel_req), .rel_off(rel_off),
`endif
    .absjump_en(absjump_en), .target(target), .depth(depth),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       aj;
    logic [9:0] tg;
    logic [2:0] dp;
    logic       ov;
    logic       un;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  logic [9:0] m_lut [8];
  logic [9:0] m_stk [$];
  bit         m_ovf, m_unf;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_lut[i] = 10'd0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Apply one cycle of stimulus, predict the outputs, then advance the model
  task automatic step(input string name, input bit rst_v, input bit ret, input bit call,
                      input bit br, input bit cond, input logic [2:0] idx, input logic [9:0] pc,
                      input bit we = 1'b0, input logic [2:0] wa = 3'd0, input logic [9:0] wd = 10'd0,
                      input bit rel = 1'b0, input logic [7:0] off = 8'd0);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_v; ret_req = ret; call_req = call; br_req = br; br_cond = cond;
    lut_idx = idx; prog_ctr = pc; lut_we = we; lut_waddr = wa; lut_wdata = wd;
    rel_req = rel; rel_off = off;
    if (!rst_v) model_reset();
    e.name = name;
    e.aj = 1'b0;
    e.tg = 10'd0;
    e.dp = 3'(m_stk.size());
    e.ov = m_ovf;
    e.un = m_unf;
    if (rst_v) begin
      if (ret) begin
        if (m_stk.size() > 0) begin e.aj = 1'b1; e.tg = m_stk[$]; end
      end else if (call) begin
        if (m_stk.size() < 4) begin e.aj = 1'b1; e.tg = m_lut[idx]; end
`ifdef JUMP_CTRL_REL_EN
      end else if (rel) begin
        if (cond) begin e.aj = 1'b1; e.tg = pc + {{2{off[7]}}, off}; end
`endif
      end else if (br && cond) begin
        e.aj = 1'b1;
        e.tg = m_lut[idx];
      end
      // state advance at the coming edge
      if (ret) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else m_unf = 1'b1;
      end else if (call) begin
        if (m_stk.size() < 4) m_stk.push_back(pc + 10'd1);
        else m_ovf = 1'b1;
      end
      if (we) m_lut[wa] = wd;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest prediction, half a cycle after drive
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (absjump_en !== e.aj || target !== e.tg || depth !== e.dp ||
            stk_ovf !== e.ov || stk_unf !== e.un) begin
          miscompares++;
          $display("FAIL %s: got aj=%0b tgt=%h depth=%0d ovf=%0b unf=%0b, expected aj=%0b tgt=%h depth=%0d ovf=%0b unf=%0b",
                   e.name, absjump_en, target, depth, stk_ovf, stk_unf, e.aj, e.tg, e.dp, e.ov, e.un);
        end
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1; prog_ctr = 10'd0; br_req = 1'b0; br_cond = 1'b0; call_req = 1'b0;
    ret_req = 1'b0; lut_idx = 3'd0; lut_we = 1'b0; lut_waddr = 3'd0; lut_wdata = 10'd0;
    rel_req = 1'b0; rel_off = 8'd0;
    model_reset();
    #2 reset = 1'b0;

    // reset held: writes and requests have no effect
    step("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'd0);
    step("rst_write", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'd0, 1'b1, 3'd5, 10'h155);
    step("rst_call", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 10'h020);
    step("rst_br", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 10'h020);
    step("rst_ret", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 10'h020);
    step("release_br5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 10'h000);
    step("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 10'h001);

    // branch
    step("wr_lut2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'h002, 1'b1, 3'd2, 10'h1A0);
    step("br_taken", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 10'h003);
    step("br_not_taken", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 10'h004);

    // call / return nesting
    step("wr_lut1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'h005, 1'b1, 3'd1, 10'h040);
    step("wr_lut3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'h006, 1'b1, 3'd3, 10'h100);
    step("call1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 10'h010);
    step("call2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 10'h041);
    step("depth2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'h101);
    step("ret1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 10'h102);
    step("ret2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 10'h043);

    // overflow then underflow
    for (int i = 0; i < 5; i++) step("ovf_call", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 10'(16 * i));
    step("ovf_flag", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'h000);
    for (int i = 0; i < 5; i++) step("unf_ret", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 10'h000);
    step("unf_flag", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'h000);

    // simultaneous requests, back-to-back call/return, PC wrap
    step("pre_call", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 10'h200);
    step("all_req", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 10'h100);
    step("only_pop", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'h201);
    step("call_wrap", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 10'h3FF);
    step("ret_wrap", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 10'h040);

    // LUT read-during-write
    step("wr_lut4_old", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'h001, 1'b1, 3'd4, 10'h0F0);
    step("rdw_old", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 10'h002, 1'b1, 3'd4, 10'h2AA);
    step("rdw_new", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 10'h003);

`ifdef JUMP_CTRL_REL_EN
    step("rel_neg", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 10'h005, 1'b0, 3'd0, 10'd0, 1'b1, 8'hF0);
`endif

    // reset in the middle of a call discards it
    step("mid_call", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 10'h050);
    step("mid_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 10'h060);
    step("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 10'h070);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [9:0] pc;
      pc = ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom);
      step("rand", ($urandom_range(0, 149) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           1'($urandom), 1'($urandom), 3'($urandom), pc,
           ($urandom_range(0, 3) == 0), 3'($urandom), 10'($urandom),
           ($urandom_range(0, 4) == 0), 8'($urandom));
    end

    // drain the scoreboard with a bounded wait
    @(posedge clk);
    #1;
    ret_req = 1'b0; call_req = 1'b0; br_req = 1'b0; lut_we = 1'b0; rel_req = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
